// File: rtl/crossbar_slave_responder.sv
// Crossbar slave responder: a small word-addressed memory behind a 4-phase
// req/ack handshake. A request is captured in IDLE, waits WAIT_CYCLES, then
// the access is performed from the captured copy and aack is raised.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for rreq; captures address/command/data on acceptance
// WAIT  | wait-state countdown before the access
// ACK   | first cycle performs the access and raises aack; then aack is
//       | held until rreq is seen low
// REL   | one dead cycle after aack falls; requests are not accepted here
module crossbar_slave_responder #(
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rreq,
   input  logic [31:0]       aaddr,
   input  logic              ccmd,
   input  logic [DATA_W-1:0] wwdata,
   output logic              aack,
   output logic [DATA_W-1:0] rrdata,
   output logic              err,
   output logic [7:0]        txn_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);
   localparam logic [DATA_W-1:0] BAD_WORD = DATA_W'(32'hDEAD_BEEF);

   typedef enum logic [1:0] {IDLE, WAIT, ACK, REL} state_t;

   state_t            state, state_nx;
   logic [3:0]        wait_cnt, wait_nx;
   logic [29:0]       cap_addr;
   logic              cap_cmd;
   logic [DATA_W-1:0] cap_data;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              range_bad;
   logic [AW-1:0]     word_idx;
   logic              access_go;
   logic              release_go;
   logic              unused_sel;

   // Crossbar port select bits carry no meaning inside the slave.
   assign unused_sel = ^aaddr[31:30];

   assign range_bad  = ((cap_addr >> (AW + 2)) != '0) || (cap_addr[1:0] != 2'b00);
   assign word_idx   = cap_addr[AW+1:2];
   // The access happens on the first edge spent in ACK, which is also the
   // edge that raises aack; this gives WAIT_CYCLES+1 edges of latency.
   assign access_go  = (state == ACK) && !aack;
   assign release_go = (state == ACK) && aack && !rreq;

   // State and wait-counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         wait_cnt <= 4'd0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_nx;
      end
   end

   // Next-state logic and wait countdown.
   always_comb begin
      state_nx = state;
      wait_nx  = wait_cnt;
      case (state)
         IDLE: begin
            if (rreq) begin
               if (WAIT_CYCLES > 0) begin
                  state_nx = WAIT;
                  wait_nx  = WAIT_LOAD;
               end else begin
                  state_nx = ACK;
               end
            end
         end
         WAIT: begin
            if (wait_cnt == 4'd0) state_nx = ACK;
            else                  wait_nx  = wait_cnt - 4'd1;
         end
         ACK: begin
            if (release_go) state_nx = REL;
         end
         REL: begin
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Request capture; later input changes never reach the access.
   always_ff @(posedge clk) begin
      if (reset) begin
         cap_addr <= '0;
         cap_cmd  <= 1'b0;
         cap_data <= '0;
      end else if (state == IDLE && rreq) begin
         cap_addr <= aaddr[29:0];
         cap_cmd  <= ccmd;
         cap_data <= wwdata;
      end
   end

   // Memory access, handshake outputs and transaction counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         aack      <= 1'b0;
         err       <= 1'b0;
         rrdata    <= '0;
         txn_count <= 8'd0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (access_go) begin
         aack      <= 1'b1;
         err       <= range_bad;
         txn_count <= txn_count + 8'd1;
         if (cap_cmd) begin
            if (!range_bad) mem[word_idx] <= cap_data;
         end else begin
            rrdata <= range_bad ? BAD_WORD : mem[word_idx];
         end
      end else if (release_go) begin
         aack <= 1'b0;
         err  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_crossbar_slave_responder.sv
// Bench for crossbar_slave_responder: directed scenarios plus randomized
// transactions checked against a word-array model of the slave.
module tb_crossbar_slave_responder;

   localparam int W = 2;
   localparam int NWORDS = 16;
   localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        reset;
   logic        rreq, ccmd;
   logic [31:0] aaddr, wwdata;
   logic        aack, err;
   logic [31:0] rrdata;
   logic [7:0]  txn_count;

   logic        rreq0, ccmd0;
   logic [31:0] aaddr0, wwdata0;
   logic        aack0, err0;
   logic [31:0] rrdata0;
   logic [7:0]  txn_count0;

   int checks = 0;
   int errors = 0;

   logic [31:0] model_mem [NWORDS];
   logic [31:0] model_rd;
   int          model_cnt;

   always #5 clk = ~clk;

   crossbar_slave_responder #(.DATA_W(32), .DEPTH(NWORDS), .WAIT_CYCLES(W)) u_dut (
      .clk(clk), .reset(reset), .rreq(rreq), .aaddr(aaddr), .ccmd(ccmd),
      .wwdata(wwdata), .aack(aack), .rrdata(rrdata), .err(err), .txn_count(txn_count)
   );

   crossbar_slave_responder #(.DATA_W(32), .DEPTH(NWORDS), .WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .reset(reset), .rreq(rreq0), .aaddr(aaddr0), .ccmd(ccmd0),
      .wwdata(wwdata0), .aack(aack0), .rrdata(rrdata0), .err(err0), .txn_count(txn_count0)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit addr_bad(input logic [31:0] a);
      return (((a & 32'h3FFF_FFFF) / (NWORDS * 4)) != 0) || ((a % 4) != 0);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NWORDS; i++) model_mem[i] = 32'h0;
      model_rd  = 32'h0;
      model_cnt = 0;
   endtask

   // One full handshake on the WAIT_CYCLES=2 instance.
   task automatic do_txn(input string tag, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, input int hold, input int exp_lat,
                         input bit settle, input bit drop_rst);
      int lat;
      bit bad;
      int idx;
      logic [31:0] exp_rd;
      @(negedge clk);
      if (drop_rst) reset = 1'b0;
      rreq = 1'b1; aaddr = addr; ccmd = wr; wwdata = data;
      lat = -1;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk); #1;
         if (aack) begin lat = n; break; end
         if (n == exp_lat - W - 1) begin
            // after acceptance the inputs may wander; the slave must ignore it
            #3; aaddr = $urandom; ccmd = 1'($urandom_range(0, 1)); wwdata = $urandom;
         end
      end
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      if (lat >= 0) begin
         bad = addr_bad(addr);
         idx = (addr / 4) % NWORDS;
         if (wr) begin
            if (!bad) model_mem[idx] = data;
            exp_rd = model_rd;
         end else begin
            exp_rd = bad ? DEADBEEF : model_mem[idx];
            model_rd = exp_rd;
         end
         model_cnt = (model_cnt + 1) % 256;
         chk({tag, "_err"}, 64'(err), 64'(bad));
         chk({tag, "_rdata"}, 64'(rrdata), 64'(exp_rd));
         chk({tag, "_cnt"}, 64'(txn_count), 64'(model_cnt));
      end
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk({tag, "_hold"}, 64'(aack), 64'(1));
      end
      @(negedge clk); rreq = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_drop"}, 64'({aack, err}), 64'(0));
      if (settle) @(posedge clk);
   endtask

   // One handshake on the WAIT_CYCLES=0 instance.
   task automatic do_w0(input string tag, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_rd, input int exp_cnt);
      int lat;
      @(negedge clk);
      rreq0 = 1'b1; aaddr0 = addr; ccmd0 = wr; wwdata0 = data;
      lat = -1;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk); #1;
         if (aack0) begin lat = n; break; end
      end
      chk({tag, "_lat"}, 64'(lat), 64'(1));
      chk({tag, "_rdata"}, 64'(rrdata0), 64'(exp_rd));
      chk({tag, "_cnt"}, 64'(txn_count0), 64'(exp_cnt));
      @(negedge clk); rreq0 = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_drop"}, 64'(aack0), 64'(0));
      @(posedge clk);
   endtask

   initial begin
      bit          wr;
      int          idx, hold, n_iter;
      logic [31:0] addr, data;

      reset = 1'b1; rreq = 1'b0; ccmd = 1'b0; aaddr = '0; wwdata = '0;
      rreq0 = 1'b0; ccmd0 = 1'b0; aaddr0 = '0; wwdata0 = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", 64'({aack, err, rrdata, txn_count}), 64'(0));

      // write/read pair; the write is issued on the edge reset drops
      do_txn("wr_a8", 1'b1, 32'h4000_0004, 32'hA800_0000, 0, W + 1, 1'b1, 1'b1);
      do_txn("rd_a8", 1'b0, 32'h4000_0004, 32'h0, 0, W + 1, 1'b1, 1'b0);

      // long hold, then a request raised in the REL cycle
      do_txn("hold10", 1'b1, 32'h0000_0008, 32'h1357_9BDF, 10, W + 1, 1'b0, 1'b0);
      do_txn("rel_req", 1'b0, 32'h0000_0008, 32'h0, 0, W + 2, 1'b1, 1'b0);

      // out-of-range read and write
      do_txn("oor_rd", 1'b0, 32'h0000_0100, 32'h0, 0, W + 1, 1'b1, 1'b0);
      do_txn("oor_wr", 1'b1, 32'h0000_0100, 32'h5555_AAAA, 1, W + 1, 1'b1, 1'b0);
      do_txn("mis_rd", 1'b0, 32'h0000_0006, 32'h0, 0, W + 1, 1'b1, 1'b0);
      for (int i = 0; i < NWORDS; i++)
         do_txn("scan", 1'b0, 32'(i * 4), 32'h0, 0, W + 1, 1'b1, 1'b0);

      // reset while a write of all-ones to word 3 is waiting
      @(negedge clk);
      rreq = 1'b1; aaddr = 32'h0000_000C; ccmd = 1'b1; wwdata = 32'hFFFF_FFFF;
      @(posedge clk);
      @(negedge clk); reset = 1'b1; rreq = 1'b0;
      @(posedge clk); #1;
      chk("midrst_aack", 64'(aack), 64'(0));
      chk("midrst_cnt", 64'(txn_count), 64'(0));
      chk("midrst_rdata", 64'(rrdata), 64'(0));
      model_reset();
      do_txn("midrst_w3", 1'b0, 32'h0000_000C, 32'h0, 0, W + 1, 1'b1, 1'b1);
      do_txn("midrst_w1", 1'b0, 32'h4000_0004, 32'h0, 0, W + 1, 1'b1, 1'b0);

      // randomized traffic, sized so the counter completes one full wrap
      n_iter = 256 - model_cnt;
      for (int i = 0; i < n_iter; i++) begin
         wr   = 1'($urandom_range(0, 1));
         idx  = $urandom_range(0, NWORDS - 1);
         addr = ($urandom_range(0, 3) << 30) | (idx << 2);
         if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 1) addr = addr | (32'h1 << $urandom_range(6, 29));
            else                           addr = addr | $urandom_range(1, 3);
         end
         data = $urandom;
         hold = $urandom_range(0, 2);
         do_txn("rand", wr, addr, data, hold, W + 1, 1'b1, 1'b0);
      end
      chk("wrap_cnt", 64'(txn_count), 64'(0));

      // zero wait states
      do_w0("w0_wr", 1'b1, 32'h8000_0008, 32'h0000_1234, 32'h0, 1);
      do_w0("w0_rd", 1'b0, 32'h0000_0008, 32'h0, 32'h0000_1234, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/crossbar_slave_responder.md
CROSSBAR_SLAVE_RESPONDER -- requirements
Module: crossbar_slave_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, port data width.
REQ-002 SHALL have parameter DEPTH, default 16, number of storage words (power of two, 2..256).
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, wait states between request capture and ack (0..15).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port rreq  input  1  request from crossbar output port.
REQ-007 SHALL have port aaddr  input  32  byte address; [31:30] crossbar port select (ignored here), word index = aaddr[log2(DEPTH)+1:2].
REQ-008 SHALL have port ccmd  input  1  1 = write, 0 = read.
REQ-009 SHALL have port wwdata  input  DATA_W  write data.
REQ-010 SHALL have port aack  output  1  acknowledge to crossbar.
REQ-011 SHALL have port rrdata  output  DATA_W  read data, valid while aack=1 for reads.
REQ-012 SHALL have port err  output  1  out-of-range access flag, valid while aack=1.
REQ-013 SHALL have port txn_count  output  8  completed transaction counter.

Function
REQ-014 SHALL implement a 4-phase handshake: master raises rreq and holds aaddr/ccmd/wwdata stable; slave raises aack; master drops rreq; slave drops aack.
REQ-015 SHALL use FSM states IDLE, WAIT, ACK, REL.
REQ-016 IDLE: on rreq=1, SHALL capture aaddr, ccmd, wwdata into internal registers and go to WAIT (WAIT_CYCLES>0) or ACK (WAIT_CYCLES=0).
REQ-017 WAIT: SHALL decrement a 4-bit counter loaded with WAIT_CYCLES-1 and go to ACK on the cycle the counter is 0.
REQ-018 On entry to ACK, SHALL perform the access using the captured values only; later changes on the inputs are ignored.
REQ-019 Latency: rreq first sampled high at edge k -> aack=1 after edge k+WAIT_CYCLES+1.
REQ-020 Write: the memory word SHALL update at the same edge that aack rises; rrdata SHALL hold its previous value.
REQ-021 Read: rrdata SHALL load the addressed word at the same edge that aack rises and hold it until the next read completes.
REQ-022 Out of range (any of aaddr[29:log2(DEPTH)+2] nonzero, or aaddr[1:0]≠0): err=1; writes SHALL be discarded; reads SHALL return 32'hDEAD_BEEF (truncated or zero-extended to DATA_W).
REQ-023 ACK: aack=1 SHALL hold while rreq=1; when rreq=0 is sampled, SHALL go to REL with aack=0 and err=0.
REQ-024 REL: SHALL go to IDLE after one cycle; a new rreq SHALL NOT be accepted in REL (minimum one idle cycle between transactions).
REQ-025 If rreq drops during WAIT (protocol violation), SHALL still complete the access, raise aack for one cycle, then take the REL path.
REQ-026 txn_count SHALL increment by 1 at each ACK entry, wrapping 255->0, and SHALL count err transactions.
REQ-027 rreq=1 held continuously after aack falls SHALL be treated as a new request only once the FSM is back in IDLE.

Reset
REQ-028 reset=1 at an edge SHALL force IDLE, aack=0, err=0, rrdata=0, txn_count=0, wait counter=0, and all memory words=0.
REQ-029 Reset SHALL take priority over every other event, including reset mid-transaction; no partial write SHALL remain.
REQ-030 After reset is deasserted, rreq=1 SHALL be accepted at the first edge.

Verification
REQ-031 Write/read: write 32'hA800_0000 to aaddr 32'h4000_0004, then read the same address -> rrdata=32'hA800_0000, err=0, aack rises 3 cycles after rreq is first sampled (WAIT_CYCLES=2).
REQ-032 Hold: keep rreq high for 10 cycles after aack -> aack stays 1; drop rreq -> aack=0 next edge; new rreq in the REL cycle -> not accepted until IDLE.
REQ-033 Error: read aaddr 32'h0000_0100 -> err=1, rrdata=32'hDEAD_BEEF; a write there leaves all words unchanged.
REQ-034 Reset mid-op: assert reset during WAIT of a write of 32'hFFFF_FFFF to word 3 -> word 3 reads 0, txn_count=0, aack=0.
REQ-035 Counter wrap: run 256 transactions -> txn_count=0; run with WAIT_CYCLES=0 -> aack rises 1 cycle after rreq is first sampled.
